// File: rtl/audio_envelope_pkg.sv
// Shared types and helpers for the audio envelope generator.
// Optional feature macro: AUDIO_ENV_RELEASE_EN (see audio_envelope.sv).
package audio_envelope_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  typedef logic [7:0] level_t;

  localparam level_t     LEVEL_MAX = 8'd255;
  localparam logic [6:0] REST_TONE = 7'd0;

  // +1 that sticks at full scale instead of wrapping
  function automatic level_t sat_inc(input level_t v);
    return (v == LEVEL_MAX) ? v : v + 8'd1;
  endfunction

  // Subtract step but never go below floor_v (and never wrap)
  function automatic level_t sat_dec(input level_t v, input level_t step, input level_t floor_v);
    if (v <= floor_v)            return floor_v;
    if ((v - floor_v) <= step)   return floor_v;
    return v - step;
  endfunction

endpackage

// File: rtl/audio_envelope_pwm.sv
// env_pwm: free-running 8-bit PWM counter and amplitude comparator.
// The output bit is registered, so it trails the level by one cycle.
module env_pwm
  import audio_envelope_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   wave,
  input  level_t level,
  output logic   aout
);

  logic [7:0] pwm_cnt;

  // Counter wraps naturally every 256 cycles; duty = level/256 while wave is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      aout    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      aout    <= en & wave & (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/audio_envelope.sv
// audio_envelope: ADSR-style amplitude envelope driving a PWM audio bit.
// Optional feature macro: AUDIO_ENV_RELEASE_EN
//   defined   -> a rest fades the level out through RELEASE
//   undefined -> a rest clears the level and returns to IDLE at once
module audio_envelope
  import audio_envelope_pkg::*;
#(
  parameter int TICK_DIV      = 1024,
  parameter int SUSTAIN_LEVEL = 160,
  parameter int DECAY_STEP    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [6:0] Tone,
  input  logic       Wave,
  output logic       AudioOut,
  output logic [7:0] Level,
  output logic       Busy
);

  localparam int         PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam level_t     SUS   = level_t'(SUSTAIN_LEVEL);
  localparam level_t     DSTEP = level_t'(DECAY_STEP);

  env_state_t    state_q, state_d;
  level_t        level_q, level_d;
  logic [6:0]    tone_q;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          note_evt;

  assign tick     = (presc_q == PMAX);
  assign note_evt = (tone_q != Tone);

  // Tone history and envelope prescaler; both run regardless of state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tone_q  <= REST_TONE;
      presc_q <= '0;
    end else begin
      tone_q  <= Tone;
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // Envelope state and level registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Next state/level: a note event pre-empts any tick step in the same cycle
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (note_evt) begin
      if (Tone != REST_TONE) begin
        // new note or retrigger; level carries on from where it is
        state_d = ATTACK;
      end else if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN) begin
`ifdef AUDIO_ENV_RELEASE_EN
        state_d = RELEASE;
`else
        state_d = IDLE;
        level_d = '0;
`endif
      end
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          level_d = sat_inc(level_q);
          if (level_d == LEVEL_MAX) state_d = DECAY;
        end
        DECAY: begin
          level_d = sat_dec(level_q, DSTEP, SUS);
          if (level_d == SUS) state_d = SUSTAIN;
        end
        RELEASE: begin
          level_d = sat_dec(level_q, 8'd1, 8'd0);
          if (level_d == 8'd0) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    Busy  = (state_q != IDLE);
    Level = level_q;
  end

  env_pwm u_pwm (
    .clk   (CLK),
    .rst_n (RST),
    .en    (EN),
    .wave  (Wave),
    .level (level_q),
    .aout  (AudioOut)
  );

endmodule

// File: tb/tb_audio_envelope.sv
// Self-checking bench for audio_envelope (TICK_DIV=4, SUSTAIN_LEVEL=160).
// A second instance with a 128 sustain level provides a steady PWM duty check.
module tb_audio_envelope;
  import audio_envelope_pkg::*;

  localparam int TD  = 4;
  localparam int SUS = 160;
`ifdef AUDIO_ENV_RELEASE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  // model phases (bench-local numbering)
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic       CLK = 1'b0, RST = 1'b0, EN = 1'b0, Wave = 1'b0;
  logic [6:0] Tone = '0, Tone2 = '0;
  logic       AudioOut, Busy, AudioOut2, Busy2;
  logic [7:0] Level, Level2;

  int checks = 0, failures = 0;

  int m_level, m_phase, m_presc, m_toneq, m_pwm;
  bit m_aout;

  always #5 CLK = ~CLK;

  audio_envelope #(.TICK_DIV(TD), .SUSTAIN_LEVEL(SUS), .DECAY_STEP(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .Tone(Tone), .Wave(Wave),
    .AudioOut(AudioOut), .Level(Level), .Busy(Busy)
  );

  audio_envelope #(.TICK_DIV(TD), .SUSTAIN_LEVEL(128), .DECAY_STEP(1)) dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .Tone(Tone2), .Wave(Wave),
    .AudioOut(AudioOut2), .Level(Level2), .Busy(Busy2)
  );

  task automatic model_reset();
    m_level = 0; m_phase = P_IDLE; m_presc = 0; m_toneq = 0; m_pwm = 0; m_aout = 1'b0;
  endtask

  // Advance one clock: compute the reference from pre-edge inputs, then sample #1 after the edge
  task automatic step();
    int lv, ph;
    bit evt, tk, ao;
    evt = (int'(Tone) != m_toneq);
    tk  = (m_presc == TD - 1);
    ao  = EN && Wave && (m_pwm < m_level);
    lv  = m_level;
    ph  = m_phase;
    if (evt) begin
      if (Tone != 0) ph = P_ATT;
      else if (ph == P_ATT || ph == P_DEC || ph == P_SUS) begin
        if (REL_EN) ph = P_REL;
        else begin ph = P_IDLE; lv = 0; end
      end
    end else if (tk) begin
      case (ph)
        P_ATT: begin lv = (lv + 1 > 255) ? 255 : lv + 1; if (lv == 255) ph = P_DEC; end
        P_DEC: begin lv = (lv - 1 < SUS) ? SUS : lv - 1; if (lv == SUS) ph = P_SUS; end
        P_REL: begin lv = (lv - 1 < 0) ? 0 : lv - 1;     if (lv == 0)   ph = P_IDLE; end
        default: ;
      endcase
    end
    @(posedge CLK);
    m_level = lv; m_phase = ph; m_toneq = int'(Tone);
    m_presc = (m_presc + 1) % TD; m_pwm = (m_pwm + 1) % 256; m_aout = ao;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; Tone = '0; Tone2 = '0; EN = 1'b0; Wave = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    checks++; if (Level !== 8'd0)    begin failures++; $display("FAIL reset_level got=%0d exp=0", Level); end
    checks++; if (Busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%0b exp=0", Busy); end
    checks++; if (AudioOut !== 1'b0) begin failures++; $display("FAIL reset_audio got=%0b exp=0", AudioOut); end
    checks++; if (Level2 !== 8'd0)   begin failures++; $display("FAIL reset_level2 got=%0d exp=0", Level2); end
  endtask

  task automatic test_attack();
    RST = 1'b1; Tone = 7'd12;
    for (int i = 1; i <= 1020; i++) begin
      step();
      checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL attack_track cyc=%0d got=%0d exp=%0d", i, Level, m_level); end
      if (i == 1) begin
        checks++; if (Busy !== 1'b1 || dut.state_q !== ATTACK) begin failures++; $display("FAIL attack_enter got=busy%0b/st%0d exp=busy1/ATTACK", Busy, dut.state_q); end
      end
      if (i == 1019) begin
        checks++; if (Level !== 8'd254) begin failures++; $display("FAIL attack_1019 got=%0d exp=254", Level); end
      end
    end
    checks++; if (Level !== 8'd255) begin failures++; $display("FAIL attack_peak got=%0d exp=255", Level); end
    checks++; if (dut.state_q !== DECAY) begin failures++; $display("FAIL attack_to_decay got=%0d exp=DECAY", dut.state_q); end
  endtask

  task automatic test_sustain();
    for (int i = 1; i <= 380; i++) begin
      step();
      checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL decay_track cyc=%0d got=%0d exp=%0d", i, Level, m_level); end
    end
    checks++; if (Level !== 8'd160) begin failures++; $display("FAIL sustain_level got=%0d exp=160", Level); end
    checks++; if (dut.state_q !== SUSTAIN || Busy !== 1'b1) begin failures++; $display("FAIL sustain_state got=st%0d/busy%0b exp=SUSTAIN/1", dut.state_q, Busy); end
  endtask

  task automatic test_retrigger();
    int n = 0;
    Tone = 7'd20;
    step();
    checks++; if (dut.state_q !== ATTACK) begin failures++; $display("FAIL retrig_state got=%0d exp=ATTACK", dut.state_q); end
    checks++; if (Level !== 8'd160) begin failures++; $display("FAIL retrig_level got=%0d exp=160", Level); end
    while (m_phase != P_SUS && n < 2000) begin
      step(); n++;
      checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL retrig_track cyc=%0d got=%0d exp=%0d", n, Level, m_level); end
    end
    checks++; if (n >= 2000 || dut.state_q !== SUSTAIN || Level !== 8'd160) begin
      failures++; $display("FAIL retrig_resettle got=st%0d/lvl%0d exp=SUSTAIN/160", dut.state_q, Level);
    end
  endtask

  task automatic test_release();
    Tone = 7'd0;
    step();
`ifdef AUDIO_ENV_RELEASE_EN
    begin
      int n = 0;
      checks++; if (dut.state_q !== RELEASE || Level !== 8'd160) begin failures++; $display("FAIL release_enter got=st%0d/lvl%0d exp=RELEASE/160", dut.state_q, Level); end
      while (Level !== 8'd0 && n < 700) begin
        step(); n++;
        checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL release_track cyc=%0d got=%0d exp=%0d", n, Level, m_level); end
      end
      checks++; if (n < 637 || n > 640) begin failures++; $display("FAIL release_time got=%0d exp=637..640", n); end
      checks++; if (Busy !== 1'b0 || dut.state_q !== IDLE) begin failures++; $display("FAIL release_idle got=busy%0b exp=0", Busy); end
    end
`else
    checks++; if (Level !== 8'd0) begin failures++; $display("FAIL rest_clear got=%0d exp=0", Level); end
    checks++; if (Busy !== 1'b0 || dut.state_q !== IDLE) begin failures++; $display("FAIL rest_idle got=busy%0b exp=0", Busy); end
`endif
  endtask

  task automatic test_pwm();
    int n = 0, hi = 0;
    EN = 1'b1; Wave = 1'b1; Tone2 = 7'd5;
    while (dut2.state_q !== SUSTAIN && n < 3000) begin step(); n++; end
    checks++; if (n >= 3000 || Level2 !== 8'd128) begin failures++; $display("FAIL pwm_settle got=%0d exp=128", Level2); end
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(AudioOut2);
      checks++; if (AudioOut !== m_aout) begin failures++; $display("FAIL pwm_main_audio cyc=%0d got=%0b exp=%0b", i, AudioOut, m_aout); end
    end
    checks++; if (hi != 128) begin failures++; $display("FAIL pwm_duty got=%0d exp=128", hi); end
    EN = 1'b0;
    step(); step();
    hi = 0;
    for (int i = 0; i < 256; i++) begin step(); hi += int'(AudioOut2) + int'(AudioOut); end
    checks++; if (hi != 0) begin failures++; $display("FAIL pwm_en_off got=%0d exp=0", hi); end
  endtask

  task automatic test_reset_mid();
    Tone = 7'd7; EN = 1'b1; Wave = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL mid_track cyc=%0d got=%0d exp=%0d", i, Level, m_level); end
    end
    checks++; if (Busy !== 1'b1 || Level === 8'd0) begin failures++; $display("FAIL mid_pre got=busy%0b/lvl%0d exp=busy1/lvl>0", Busy, Level); end
    #2 RST = 1'b0;
    #1;
    model_reset();
    checks++; if (Level !== 8'd0 || Busy !== 1'b0 || AudioOut !== 1'b0) begin
      failures++; $display("FAIL mid_async got=lvl%0d/busy%0b/aud%0b exp=0/0/0", Level, Busy, AudioOut);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    step();
    checks++; if (dut.state_q !== ATTACK || Busy !== 1'b1 || Level !== 8'd0) begin
      failures++; $display("FAIL mid_restart got=st%0d/busy%0b/lvl%0d exp=ATTACK/1/0", dut.state_q, Busy, Level);
    end
  endtask

  task automatic test_random();
    int tones[4] = '{0, 3, 9, 12};
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) Tone = 7'(tones[$urandom_range(0, 3)]);
      Wave = 1'($urandom_range(0, 1));
      EN   = ($urandom_range(0, 7) != 0);
      step();
      checks++; if (Level !== 8'(m_level)) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, Level, m_level); end
      checks++; if (Busy !== (m_phase != P_IDLE)) begin failures++; $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", i, Busy, (m_phase != P_IDLE)); end
      checks++; if (AudioOut !== m_aout) begin failures++; $display("FAIL rand_audio cyc=%0d got=%0b exp=%0b", i, AudioOut, m_aout); end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_sustain();
    test_retrigger();
    test_release();
    test_pwm();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
